uart_tx_arbiter: RTL

//  Round-robin packet arbiter that shares the UART transmit path among N requesters.
//  - Sits between N byte-stream clients and the uartTop TX FIFO write port (writeData/writeUART/txFull).
//  - Grants one requester at a time and holds the grant until that requester's last byte is written,
//    so packets never interleave on the serial line.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, default data width
// and a small modulo helper.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arbStateT;

  localparam int UART_DBITS = 8;

  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uartTop TX FIFO write port, bundled for the arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int dBits = UART_DBITS
);

  // A byte of requester i moves on a cycle where reqValid[i] & reqReady[i]; the requester
  // keeps reqValid/reqData/reqLast stable until then. writeUART strobes once per byte.
  logic [N-1:0]       reqValid;
  logic [N*dBits-1:0] reqData;
  logic [N-1:0]       reqLast;
  logic [N-1:0]       reqReady;
  logic [dBits-1:0]   writeData;
  logic               writeUART;
  logic               txFull;

  modport master (
    output reqValid, reqData, reqLast, txFull,
    input  reqReady, writeData, writeUART
  );

  modport slave (
    input  reqValid, reqData, reqLast, txFull,
    output reqReady, writeData, writeUART
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  int cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the uartTop TX FIFO; a grant is held until the
// owner's last byte. Optional in-packet idle timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int dBits   = UART_DBITS,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  uart_tx_arbiter_if.slave     bus,
  output logic [$clog2(N)-1:0] grantId,
  output logic                 busy,
  output logic                 timeoutErr,
  output arbStateT             dbgState
);

  localparam int W = $clog2(N);

  if (N < 2 || TIMEOUT < 2) begin : gBadParams
    $error("uart_tx_arbiter: N and TIMEOUT must both be >= 2");
  end

  arbStateT       state, stateNext;
  logic [W-1:0]   grantNext;
  logic [W-1:0]   ptr, ptrNext;
  logic           pickAny;
  logic [W-1:0]   pickIdx;
  logic           ownerValid, ownerLast, locked, xfer, timeoutHit;

  rr_pick #(.N(N)) uPick (
    .req (bus.reqValid),
    .ptr (ptr),
    .any (pickAny),
    .idx (pickIdx)
  );

  assign locked     = (state == ST_LOCK);
  assign ownerValid = bus.reqValid[grantId];
  assign ownerLast  = bus.reqLast[grantId];
  assign xfer       = locked && ownerValid && !bus.txFull;

  // No skid buffer: ready and the write strobe come straight from the grant and txFull.
  assign bus.reqReady  = (locked && !bus.txFull) ? (N'(1) << grantId) : '0;
  assign bus.writeUART = xfer;
  assign bus.writeData = locked ? bus.reqData[grantId*dBits +: dBits] : '0;

  assign busy     = locked;
  assign dbgState = state;

  always_comb begin
    stateNext = state;
    grantNext = grantId;
    ptrNext   = ptr;
    case (state)
      ST_IDLE: begin
        if (pickAny) begin
          stateNext = ST_LOCK;
          grantNext = pickIdx;
        end
      end
      ST_LOCK: begin
        if ((xfer && ownerLast) || timeoutHit) begin
          stateNext = ST_IDLE;
          ptrNext   = W'(wrapInc(int'(grantId), N));
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      grantId <= '0;
      ptr     <= '0;
    end else begin
      state   <= stateNext;
      grantId <= grantNext;
      ptr     <= ptrNext;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] idleCnt;

  // txFull stalls keep the owner valid, so they never advance the counter.
  assign timeoutHit = locked && !ownerValid && (idleCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idleCnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= timeoutHit;
      if (!locked || xfer || timeoutHit) begin
        idleCnt <= '0;
      end else if (!ownerValid) begin
        idleCnt <= idleCnt + 1'b1;
      end
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign timeoutErr = 1'b0;
`endif

endmodule
